sram_access_ctrl: RTL and testbench

- Sequencer and two-port arbiter for the DMG on-chip static RAM macro: 8 bit lanes, a 32-row array and a 4-column bit-line mux.
- Accepts read/write requests from port A (CPU side) and port B (DMA/secondary side), and grants one at a time.
- Generates the precharge, row-decode, word-line, column-select, output-enable and write strobes for the array in a fixed cycle sequence.
- Returns read data and a one-cycle acknowledge to the granted port.

---
 rtl/sram_access_ctrl.sv | 158 +++++++++++++++
 tb/tb_sram_access_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - two-port arbiter and strobe sequencer for the DMG static RAM macro
`timescale 1ns/1ps
module sram_access_ctrl #(
    parameter int ACC_CYCLES = 1,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       CLK,
    input  logic       n_RESET,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [6:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_ack,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [6:0] b_addr,
    input  logic [7:0] b_wdata,
    output logic       b_ack,
    output logic [7:0] b_rdata,
    output logic       n_pch,
    output logic       n_wl_pch,
    output logic       wl_ena,
    output logic [4:0] row_d,
    output logic [4:0] row_nd,
    output logic [3:0] col,
    output logic       oe,
    output logic       n_oe,
    output logic       wr,
    output logic [7:0] db_out,
    output logic       db_drv,
    input  logic [7:0] db_in,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SETUP, ACC, DONE} state_t;

    localparam logic [1:0] ACC_LAST = 2'(ACC_CYCLES - 1);

    state_t     state;
    logic       lat_we;
    logic [6:0] lat_addr;
    logic       grant_b;
    // Set when A held the most recent grant; reset clear so A wins the first tie.
    logic       last_a;
    logic [1:0] acc_cnt;

    logic       pick_b;
    logic       win_we;
    logic [6:0] win_addr;
    logic [7:0] win_wdata;
    logic [3:0] col_onehot;

    // Choose the winner among current requesters and mux its request fields.
    always_comb begin
        pick_b = 1'b0;
        if (b_req && !a_req) begin
            pick_b = 1'b1;
        end else if (a_req && b_req) begin
            pick_b = FIXED_PRIO ? 1'b0 : last_a;
        end
        win_we     = pick_b ? b_we    : a_we;
        win_addr   = pick_b ? b_addr  : a_addr;
        win_wdata  = pick_b ? b_wdata : a_wdata;
        col_onehot = 4'b0001 << lat_addr[1:0];
    end

    assign n_oe = ~oe;
    assign busy = (state != IDLE);

    // Access sequencer: every array strobe is a flop loaded on the state transition.
    always_ff @(posedge CLK or negedge n_RESET) begin
        if (!n_RESET) begin
            state    <= IDLE;
            lat_we   <= 1'b0;
            lat_addr <= '0;
            grant_b  <= 1'b0;
            last_a   <= 1'b0;
            acc_cnt  <= '0;
            n_pch    <= 1'b0;
            n_wl_pch <= 1'b0;
            wl_ena   <= 1'b0;
            row_d    <= '0;
            row_nd   <= 5'h1F;
            col      <= '0;
            oe       <= 1'b0;
            wr       <= 1'b0;
            db_out   <= '0;
            db_drv   <= 1'b0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        grant_b  <= pick_b;
                        last_a   <= ~pick_b;
                        lat_we   <= win_we;
                        lat_addr <= win_addr;
                        row_d    <= win_addr[6:2];
                        row_nd   <= ~win_addr[6:2];
                        n_pch    <= 1'b1;
                        n_wl_pch <= 1'b1;
                        if (win_we) begin
                            db_out <= win_wdata;
                            db_drv <= 1'b1;
                        end
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    wl_ena  <= 1'b1;
                    col     <= col_onehot;
                    oe      <= ~lat_we;
                    wr      <= lat_we;
                    db_drv  <= lat_we;
                    acc_cnt <= '0;
                    state   <= ACC;
                end
                ACC: begin
                    if (acc_cnt == ACC_LAST) begin
                        wl_ena <= 1'b0;
                        col    <= '0;
                        oe     <= 1'b0;
                        wr     <= 1'b0;
                        db_drv <= 1'b0;
                        if (!lat_we) begin
                            if (grant_b) begin
                                b_rdata <= db_in;
                            end else begin
                                a_rdata <= db_in;
                            end
                        end
                        if (grant_b) begin
                            b_ack <= 1'b1;
                        end else begin
                            a_ack <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        acc_cnt <= acc_cnt + 2'd1;
                    end
                end
                DONE: begin
                    n_pch    <= 1'b0;
                    n_wl_pch <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - directed self-checking bench for sram_access_ctrl
`timescale 1ns/1ps
module tb_sram_access_ctrl;

    logic       CLK = 1'b0;
    logic       n_RESET0, n_RESET1;
    logic       a_req, a_we, b_req, b_we;
    logic [6:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata, db_in;

    logic       a_ack0, b_ack0, n_pch0, n_wl_pch0, wl_ena0, oe0, n_oe0, wr0, db_drv0, busy0;
    logic [7:0] a_rdata0, b_rdata0, db_out0;
    logic [4:0] row_d0, row_nd0;
    logic [3:0] col0;

    logic       a_ack1, b_ack1, n_pch1, n_wl_pch1, wl_ena1, oe1, n_oe1, wr1, db_drv1, busy1;
    logic [7:0] a_rdata1, b_rdata1, db_out1;
    logic [4:0] row_d1, row_nd1;
    logic [3:0] col1;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    sram_access_ctrl #(.ACC_CYCLES(1), .FIXED_PRIO(1'b0)) dut0 (
        .CLK(CLK), .n_RESET(n_RESET0),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack0), .a_rdata(a_rdata0),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack0), .b_rdata(b_rdata0),
        .n_pch(n_pch0), .n_wl_pch(n_wl_pch0), .wl_ena(wl_ena0),
        .row_d(row_d0), .row_nd(row_nd0), .col(col0),
        .oe(oe0), .n_oe(n_oe0), .wr(wr0),
        .db_out(db_out0), .db_drv(db_drv0), .db_in(db_in), .busy(busy0)
    );

    sram_access_ctrl #(.ACC_CYCLES(3), .FIXED_PRIO(1'b1)) dut1 (
        .CLK(CLK), .n_RESET(n_RESET1),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack1), .a_rdata(a_rdata1),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack1), .b_rdata(b_rdata1),
        .n_pch(n_pch1), .n_wl_pch(n_wl_pch1), .wl_ena(wl_ena1),
        .row_d(row_d1), .row_nd(row_nd1), .col(col1),
        .oe(oe1), .n_oe(n_oe1), .wr(wr1),
        .db_out(db_out1), .db_drv(db_drv1), .db_in(db_in), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle array safety rules on whichever instance is out of reset.
    always @(negedge CLK) begin
        if (n_RESET0) begin
            chk("inv0_wl_pch", 32'(wl_ena0 && !n_pch0), 32'd0);
            chk("inv0_oe_wr",  32'(oe0 && wr0), 32'd0);
            chk("inv0_col",    32'((col0 != 4'd0) && !wl_ena0), 32'd0);
            chk("inv0_n_oe",   32'(n_oe0), 32'(!oe0));
        end
        if (n_RESET1) begin
            chk("inv1_wl_pch", 32'(wl_ena1 && !n_pch1), 32'd0);
            chk("inv1_oe_wr",  32'(oe1 && wr1), 32'd0);
            chk("inv1_col",    32'((col1 != 4'd0) && !wl_ena1), 32'd0);
            chk("inv1_n_oe",   32'(n_oe1), 32'(!oe1));
        end
    end

    initial begin
        n_RESET0 = 1'b0; n_RESET1 = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        db_in = '0;
        repeat (2) @(negedge CLK);

        // reset state
        chk("rst_n_pch",    32'(n_pch0), 32'd0);
        chk("rst_n_wl_pch", 32'(n_wl_pch0), 32'd0);
        chk("rst_strobes",  32'({wl_ena0, oe0, wr0, db_drv0, busy0}), 32'd0);
        chk("rst_n_oe",     32'(n_oe0), 32'd1);
        chk("rst_col",      32'(col0), 32'd0);
        chk("rst_row_d",    32'(row_d0), 32'd0);
        chk("rst_row_nd",   32'(row_nd0), 32'h1F);
        chk("rst_acks",     32'({a_ack0, b_ack0}), 32'd0);
        chk("rst_rdata",    32'({a_rdata0, b_rdata0}), 32'd0);
        n_RESET0 = 1'b1;
        @(negedge CLK);
        chk("idle_n_pch", 32'(n_pch0), 32'd0);

        // A read at 7'h25
        a_req = 1'b1; a_we = 1'b0; a_addr = 7'h25;
        @(negedge CLK);
        chk("t1_setup_busy",   32'(busy0), 32'd1);
        chk("t1_setup_pch",    32'({n_pch0, n_wl_pch0}), 32'd3);
        chk("t1_setup_row_d",  32'(row_d0), 32'h09);
        chk("t1_setup_row_nd", 32'(row_nd0), 32'h16);
        chk("t1_setup_wl",     32'(wl_ena0), 32'd0);
        @(negedge CLK);
        chk("t1_acc_wl",   32'(wl_ena0), 32'd1);
        chk("t1_acc_col",  32'(col0), 32'b0010);
        chk("t1_acc_oe",   32'({oe0, n_oe0, wr0}), 32'b100);
        chk("t1_acc_ack",  32'(a_ack0), 32'd0);
        db_in = 8'hA5;
        @(negedge CLK);
        chk("t1_done_a_ack", 32'(a_ack0), 32'd1);
        chk("t1_done_rdata", 32'(a_rdata0), 32'hA5);
        chk("t1_done_b_ack", 32'(b_ack0), 32'd0);
        chk("t1_done_wl",    32'({wl_ena0, col0}), 32'd0);
        a_req = 1'b0; db_in = 8'h00;
        @(negedge CLK);
        chk("t1_idle_ack",  32'(a_ack0), 32'd0);
        chk("t1_idle_busy", 32'(busy0), 32'd0);
        chk("t1_idle_pch",  32'(n_pch0), 32'd0);

        // B write 7'h7F <- 8'h3C
        b_req = 1'b1; b_we = 1'b1; b_addr = 7'h7F; b_wdata = 8'h3C;
        @(negedge CLK);
        chk("t2_setup_drv",   32'(db_drv0), 32'd1);
        chk("t2_setup_dout",  32'(db_out0), 32'h3C);
        chk("t2_setup_row",   32'(row_d0), 32'h1F);
        chk("t2_setup_wr",    32'(wr0), 32'd0);
        @(negedge CLK);
        chk("t2_acc_wr",   32'(wr0), 32'd1);
        chk("t2_acc_col",  32'(col0), 32'b1000);
        chk("t2_acc_oe",   32'(oe0), 32'd0);
        chk("t2_acc_drv",  32'(db_drv0), 32'd1);
        chk("t2_acc_dout", 32'(db_out0), 32'h3C);
        @(negedge CLK);
        chk("t2_done_b_ack",   32'(b_ack0), 32'd1);
        chk("t2_done_a_ack",   32'(a_ack0), 32'd0);
        chk("t2_done_b_rdata", 32'(b_rdata0), 32'h00);
        chk("t2_done_a_rdata", 32'(a_rdata0), 32'hA5);
        b_req = 1'b0; b_we = 1'b0;
        @(negedge CLK);

        // both held: round robin A,B,A,B every 4 cycles
        a_req = 1'b1; b_req = 1'b1; a_addr = 7'h01; b_addr = 7'h42; db_in = 8'h77;
        for (int i = 1; i <= 16; i++) begin
            @(negedge CLK);
            chk($sformatf("rr_a_ack_c%0d", i), 32'(a_ack0), 32'((i == 3) || (i == 11)));
            chk($sformatf("rr_b_ack_c%0d", i), 32'(b_ack0), 32'((i == 7) || (i == 15)));
        end
        a_req = 1'b0; b_req = 1'b0;
        chk("rr_a_rdata", 32'(a_rdata0), 32'h77);
        chk("rr_b_rdata", 32'(b_rdata0), 32'h77);
        @(negedge CLK);
        chk("rr_idle_busy", 32'(busy0), 32'd0);

        // reset during the ACC cycle of a write
        a_req = 1'b1; a_we = 1'b1; a_addr = 7'h00; a_wdata = 8'hFF;
        @(negedge CLK);
        @(negedge CLK);
        chk("rm_acc_wr", 32'({wl_ena0, wr0}), 32'b11);
        n_RESET0 = 1'b0;
        #1;
        chk("rm_wl",    32'(wl_ena0), 32'd0);
        chk("rm_wr",    32'(wr0), 32'd0);
        chk("rm_n_pch", 32'(n_pch0), 32'd0);
        chk("rm_drv",   32'({db_drv0, busy0}), 32'd0);
        a_req = 1'b0; a_we = 1'b0;
        @(negedge CLK);
        chk("rm_no_ack", 32'(a_ack0), 32'd0);
        n_RESET0 = 1'b1;
        @(negedge CLK);
        a_req = 1'b1; a_addr = 7'h25; db_in = 8'hC3;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            chk($sformatf("rm_fresh_ack_c%0d", i), 32'(a_ack0), 32'(i == 3));
            if (i == 3) begin
                chk("rm_fresh_rdata", 32'(a_rdata0), 32'hC3);
                a_req = 1'b0;
            end
        end

        // second instance: ACC_CYCLES=3, fixed priority
        n_RESET0 = 1'b0; n_RESET1 = 1'b1;
        @(negedge CLK);
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0; db_in = 8'h11;
        for (int i = 1; i <= 18; i++) begin
            @(negedge CLK);
            chk($sformatf("fp_a_ack_c%0d", i), 32'(a_ack1), 32'((i == 5) || (i == 11) || (i == 17)));
            chk($sformatf("fp_b_ack_c%0d", i), 32'(b_ack1), 32'd0);
        end
        a_req = 1'b0; b_req = 1'b0;
        chk("fp_a_rdata", 32'(a_rdata1), 32'h11);
        chk("fp_b_rdata", 32'(b_rdata1), 32'h00);
        @(negedge CLK);

        // three-cycle word line, capture only at the last ACC edge
        a_req = 1'b1; a_addr = 7'h25; db_in = 8'h00;
        for (int i = 1; i <= 5; i++) begin
            @(negedge CLK);
            chk($sformatf("acc3_wl_c%0d", i), 32'(wl_ena1), 32'((i >= 2) && (i <= 4)));
            if (i == 4) db_in = 8'h5A;
            if (i == 5) begin
                chk("acc3_ack",   32'(a_ack1), 32'd1);
                chk("acc3_rdata", 32'(a_rdata1), 32'h5A);
                a_req = 1'b0;
            end
        end
        @(negedge CLK);
        chk("acc3_idle", 32'({wl_ena1, busy1}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
